// File: rtl/shift_unit_arbiter_pkg.sv
// shift_unit_arbiter_pkg: shift operation encodings and widths shared by the shift unit arbiter
package shift_unit_arbiter_pkg;
   localparam int SHIFT_W = 16;
   localparam int SHAMT_W = 4;
   localparam logic [1:0] SIG_NOP = 2'b00;
   localparam logic [1:0] SIG_SLL = 2'b01;
   localparam logic [1:0] SIG_SRL = 2'b10;
   localparam logic [1:0] SIG_SRA = 2'b11;
endpackage

// File: rtl/shift_unit_arbiter_rr.sv
// rr_arbiter: combinational one-hot round-robin grant starting the search at ptr
module rr_arbiter #(
   parameter int N = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);
   always_comb begin
      grant = '0;
      for (int k = 0; k < N; k++) begin
         if (grant == '0 && req[(int'(ptr) + k) % N])
            grant[(int'(ptr) + k) % N] = 1'b1;
      end
   end
endmodule

// File: rtl/shift_unit_arbiter_shifter.sv
// shifter16_4: 16-bit shifter with 4-bit amount, zero-fill logical and sign-fill arithmetic modes
module shifter16_4
   import shift_unit_arbiter_pkg::*;
(
   input  logic [SHIFT_W-1:0] a,
   input  logic [SHAMT_W-1:0] shf,
   input  logic [1:0]         sigs,
   output logic [SHIFT_W-1:0] b
);
   // Computed apart so the unsigned ternary context cannot turn >>> into a logical shift
   logic signed [SHIFT_W-1:0] sra;
   assign sra = $signed(a) >>> shf;
   always_comb
      b = sigs == SIG_SLL ? a << shf :
          sigs == SIG_SRL ? a >> shf :
          sigs == SIG_SRA ? sra      : a;
endmodule

// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: round-robin sharing of one shifter16_4 among NREQ requesters
//  with a registered one-cycle result and per-requester response backpressure
module shift_unit_arbiter
   import shift_unit_arbiter_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*SHIFT_W-1:0] req_a,
   input  logic [NREQ*SHAMT_W-1:0] req_shft,
   input  logic [NREQ*2-1:0]       req_sigs,
   output logic [NREQ-1:0]         rsp_valid,
   input  logic [NREQ-1:0]         rsp_ready,
   output logic [SHIFT_W-1:0]      rsp_data
);
   localparam int W = SHIFT_W;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   logic [PW-1:0]      ptr, owner, gidx;
   logic [NREQ-1:0]    grant;
   logic [W-1:0]       sel_a, shf_out, result;
   logic [SHAMT_W-1:0] sel_shft;
   logic [1:0]         sel_sigs;
   logic               full, can_issue, accept;
   rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant)
   );
   assign full      = |rsp_valid;
   assign can_issue = ~full | rsp_ready[owner];
   assign req_ready = grant & {NREQ{can_issue}};
   assign accept    = |req_ready;
   always_comb begin
      sel_a    = '0;
      sel_shft = '0;
      sel_sigs = SIG_NOP;
      gidx     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_a    = req_a[i*W +: W];
            sel_shft = req_shft[i*SHAMT_W +: SHAMT_W];
            sel_sigs = req_sigs[i*2 +: 2];
            gidx     = PW'(i);
         end
      end
   end
   shifter16_4 u_shift (
      .a    (sel_a),
      .shf  (sel_shft),
      .sigs (sel_sigs),
      .b    (shf_out)
   );
   assign result = sel_sigs == SIG_NOP ? sel_a : shf_out;
   // A drain without a refill clears valid but leaves the last data on the bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
         owner     <= '0;
         ptr       <= '0;
      end else if (accept) begin
         rsp_valid <= grant;
         rsp_data  <= result;
         owner     <= gidx;
         ptr       <= gidx == PW'(NREQ - 1) ? '0 : gidx + 1'b1;
      end else if (full && rsp_ready[owner]) begin
         rsp_valid <= '0;
      end
   end
endmodule
